// File: rtl/fifo_prog.sv
// -----------------------------------------------------------------------------
// fifo_prog -- parametrised single-clock FIFO
//
// Buffers words between a producer and a consumer in one clock domain.
// Supports any depth >= 2, programmable almost-full/almost-empty levels,
// a fill-level count, a synchronous flush and an optional first-word-
// fall-through (FWFT) read mode.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   flush        synchronous clear of contents (overrides wr_en/rd_en)
//   data_in      write data
//   wr_en        write request
//   rd_en        read request
//   data_out     read data (registered, or head word when FWFT=1)
//   wr_ack       pulse: previous-cycle write accepted
//   overflow     pulse: previous-cycle write rejected (FIFO full)
//   underflow    pulse: previous-cycle read rejected (FIFO empty)
//   full         count == FIFO_DEPTH
//   empty        count == 0
//   almostfull   count >= AF_THRESH
//   almostempty  count <= AE_THRESH
//   count        number of stored words
//
// Handshake: a request is sampled on every rising edge. A write is accepted
// when wr_en=1 and the FIFO is not full; a read is accepted when rd_en=1 and
// the FIFO is not empty. Acceptance of one never depends on the other, so a
// full FIFO can read and write in the same cycle only as "read accepted,
// write rejected", and an empty FIFO as "write accepted, read rejected".
// The outcome is reported one cycle later on wr_ack/overflow/underflow.
// -----------------------------------------------------------------------------
module fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  // Parameter legality
  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("fifo_prog: FIFO_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("fifo_prog: FIFO_DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("fifo_prog: AF_THRESH must be in 1..FIFO_DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("fifo_prog: AE_THRESH must be in 0..FIFO_DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("fifo_prog: FWFT must be 0 or 1");
  end

  logic [FIFO_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status flags straight from the count register
  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= CW'(AF_THRESH));
  assign almostempty = (count <= CW'(AE_THRESH));

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage is deliberately not reset; stale words are never visible because
  // the pointers and count are.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, count and pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Explicit wrap keeps non-power-of-two depths inside the array
      if (wr_ok) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // Read data path
  if (FWFT == 1) begin : g_fwft
    // Head word is always presented; it is meaningless while empty.
    assign data_out = mem[rd_ptr];
  end else begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_out <= '0;
      end else if (rd_ok && !flush) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_fifo_prog -- bench for fifo_prog
//
// Three instances share one stimulus stream:
//   u0: defaults (depth 8, AF 7, AE 1, registered read)
//   u1: depth 5, AF 4, AE 2, registered read
//   u2: defaults with FWFT=1
// A queue-based reference model per instance predicts every output after
// every edge; directed steps add constant expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_fifo_prog;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] din   = '0;

  logic [15:0] dout  [3];
  logic        wack  [3];
  logic        ovf   [3];
  logic        udf   [3];
  logic        fullf [3];
  logic        emptf [3];
  logic        af    [3];
  logic        ae    [3];
  logic [3:0]  cnt0;
  logic [2:0]  cnt1;
  logic [3:0]  cnt2;

  fifo_prog u0 (
    .clk(clk), .rst(rst), .flush(flush), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout[0]), .wr_ack(wack[0]), .overflow(ovf[0]), .underflow(udf[0]),
    .full(fullf[0]), .empty(emptf[0]), .almostfull(af[0]), .almostempty(ae[0]), .count(cnt0)
  );

  fifo_prog #(.FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(2)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout[1]), .wr_ack(wack[1]), .overflow(ovf[1]), .underflow(udf[1]),
    .full(fullf[1]), .empty(emptf[1]), .almostfull(af[1]), .almostempty(ae[1]), .count(cnt1)
  );

  fifo_prog #(.FWFT(1)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout[2]), .wr_ack(wack[2]), .overflow(ovf[2]), .underflow(udf[2]),
    .full(fullf[2]), .empty(emptf[2]), .almostfull(af[2]), .almostempty(ae[2]), .count(cnt2)
  );

  // ---------------------------------------------------------------- model state
  int m_depth [3] = '{8, 5, 8};
  int m_af    [3] = '{7, 4, 7};
  int m_ae    [3] = '{1, 2, 1};
  int m_fwft  [3] = '{0, 0, 1};

  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  logic [15:0] exp_q2 [$];
  logic [15:0] exp_dout [3];
  logic        exp_wack [3];
  logic        exp_ovf  [3];
  logic        exp_udf  [3];

  int vectors    = 0;
  int miscompares = 0;

  function automatic int cnt_of(int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int size_of(int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [15:0] head_of(int k);
    case (k)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s u%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    for (int k = 0; k < 3; k++) begin
      exp_dout[k] = '0;
      exp_wack[k] = 1'b0;
      exp_ovf[k]  = 1'b0;
      exp_udf[k]  = 1'b0;
    end
  endtask

  // One edge of FIFO behaviour, stated in terms of a word queue
  task automatic model_step(int k);
    logic [15:0] q [$];
    logic [15:0] hd;
    logic        can_rd;
    logic        can_wr;
    case (k)
      0:       q = exp_q0;
      1:       q = exp_q1;
      default: q = exp_q2;
    endcase
    if (flush) begin
      q.delete();
      exp_wack[k] = 1'b0;
      exp_ovf[k]  = 1'b0;
      exp_udf[k]  = 1'b0;
    end else begin
      can_rd      = rd_en && (q.size() != 0);
      can_wr      = wr_en && (q.size() != m_depth[k]);
      exp_wack[k] = can_wr;
      exp_ovf[k]  = wr_en && (q.size() == m_depth[k]);
      exp_udf[k]  = rd_en && (q.size() == 0);
      if (can_rd) begin
        hd = q.pop_front();
        if (m_fwft[k] == 0) exp_dout[k] = hd;
      end
      if (can_wr) q.push_back(din);
    end
    case (k)
      0:       exp_q0 = q;
      1:       exp_q1 = q;
      default: exp_q2 = q;
    endcase
  endtask

  task automatic check_all();
    int sz;
    for (int k = 0; k < 3; k++) begin
      sz = size_of(k);
      chk("count", k, 32'(cnt_of(k)), 32'(sz));
      chk("full", k, 32'(fullf[k]), 32'(sz == m_depth[k]));
      chk("empty", k, 32'(emptf[k]), 32'(sz == 0));
      chk("almostfull", k, 32'(af[k]), 32'(sz >= m_af[k]));
      chk("almostempty", k, 32'(ae[k]), 32'(sz <= m_ae[k]));
      chk("wr_ack", k, 32'(wack[k]), 32'(exp_wack[k]));
      chk("overflow", k, 32'(ovf[k]), 32'(exp_ovf[k]));
      chk("underflow", k, 32'(udf[k]), 32'(exp_udf[k]));
      if (m_fwft[k] == 1) begin
        if (sz > 0) chk("data_out_fwft", k, 32'(dout[k]), 32'(head_of(k)));
      end else begin
        chk("data_out", k, 32'(dout[k]), 32'(exp_dout[k]));
      end
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Inputs change just after the falling edge; outputs are checked at the
  // next falling edge, half a cycle after the active edge.
  task automatic cycle(logic w, logic r, logic [15:0] d, logic f);
    wr_en = w;
    rd_en = r;
    din   = d;
    flush = f;
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    check_all();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [15:0] order [7];
    logic        w;
    logic        r;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b0;

    // 1. Fill and overflow
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 16'(i + 1), 1'b0);
      chk("p1_wack", 0, 32'(wack[0]), 32'd1);
      chk("p1_count", 0, 32'(cnt0), 32'(i + 1));
      chk("p1_af", 0, 32'(af[0]), 32'((i + 1) >= 7));
    end
    chk("p1_full", 0, 32'(fullf[0]), 32'd1);
    cycle(1'b1, 1'b0, 16'h0009, 1'b0);
    chk("p1_ovf", 0, 32'(ovf[0]), 32'd1);
    chk("p1_wack9", 0, 32'(wack[0]), 32'd0);
    chk("p1_count9", 0, 32'(cnt0), 32'd8);

    // 2. Drain and underflow
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      chk("p2_dout", 0, 32'(dout[0]), 32'(i + 1));
    end
    chk("p2_empty", 0, 32'(emptf[0]), 32'd1);
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("p2_udf", 0, 32'(udf[0]), 32'd1);
    chk("p2_hold", 0, 32'(dout[0]), 32'h0008);

    // 3. Simultaneous requests on full, then on empty
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'(16'h0010 + i), 1'b0);
    cycle(1'b1, 1'b1, 16'h0099, 1'b0);
    chk("p3_head", 0, 32'(dout[0]), 32'h0010);
    chk("p3_ovf", 0, 32'(ovf[0]), 32'd1);
    chk("p3_count", 0, 32'(cnt0), 32'd7);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b1, 16'h0055, 1'b0);
    chk("p3_udf", 0, 32'(udf[0]), 32'd1);
    chk("p3_count1", 0, 32'(cnt0), 32'd1);
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("p3_word", 0, 32'(dout[0]), 32'h0055);

    // 4. Wrap and thresholds on the depth-5 instance
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 7; i++) order[i] = 16'(16'h00A0 + i);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, order[i], 1'b0);
    chk("p4_full", 1, 32'(fullf[1]), 32'd1);
    chk("p4_af5", 1, 32'(af[1]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      chk("p4_order", 1, 32'(dout[1]), 32'(order[i]));
    end
    chk("p4_af3", 1, 32'(af[1]), 32'd0);
    chk("p4_ae3", 1, 32'(ae[1]), 32'd0);
    for (int i = 5; i < 7; i++) cycle(1'b1, 1'b0, order[i], 1'b0);
    for (int i = 2; i < 7; i++) begin
      cycle(1'b0, 1'b1, 16'h0000, 1'b0);
      chk("p4_order", 1, 32'(dout[1]), 32'(order[i]));
      chk("p4_ae", 1, 32'(ae[1]), 32'((6 - i) <= 2));
    end

    // 5. Flush with a concurrent write
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'(16'h0030 + i), 1'b0);
    cycle(1'b1, 1'b0, 16'h0077, 1'b1);
    chk("p5_count", 0, 32'(cnt0), 32'd0);
    chk("p5_empty", 0, 32'(emptf[0]), 32'd1);
    chk("p5_wack", 0, 32'(wack[0]), 32'd0);

    // 6. FWFT presentation and pop
    cycle(1'b1, 1'b0, 16'hABCD, 1'b0);
    chk("p6_fwft", 2, 32'(dout[2]), 32'h0000ABCD);
    chk("p6_nempty", 2, 32'(emptf[2]), 32'd0);
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("p6_empty", 2, 32'(emptf[2]), 32'd1);

    // Randomized traffic, alternating write-heavy and read-heavy stretches,
    // with one asynchronous reset landing mid-burst between edges.
    for (int i = 0; i < 1600; i++) begin
      if (i == 700) begin
        wr_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_rst_dout", 0, 32'(dout[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
      end
      if (((i / 100) % 2) == 0) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 3);
      end else begin
        w = ($urandom_range(0, 9) < 3);
        r = ($urandom_range(0, 9) < 7);
      end
      cycle(w, r, 16'($urandom), ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
